muldiv_sched: RTL and testbench

//  Sequences the multi-cycle multiply/divide resources for the EX stage. Accepts one MULT/MULTU/DIV/DIVU
//  op at a time, starts the fixed-latency pipelined multiplier or the handshaked iterative divider,

---
 rtl/muldiv_sched_if.sv | 44 ++++
 rtl/muldiv_sched.sv | 135 +++++++++++++
 tb/tb_muldiv_sched.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sched_if.sv
// Handshake bundle between the EX-stage mult/div scheduler and its neighbours:
// the EX op source, the pipelined multiplier, the iterative divider and HI/LO.
// The slave side is the scheduler. The master side is everything around it.
interface muldiv_sched_if #(
    parameter int WIDTH = 32
);
    logic                 op_valid;
    logic [1:0]           op_code;
    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    logic                 flush;

    logic                 mul_start;
    logic                 mul_signed;
    logic [WIDTH-1:0]     mul_a;
    logic [WIDTH-1:0]     mul_b;
    logic [2*WIDTH-1:0]   mul_result;

    logic                 div_start;
    logic                 div_cancel;
    logic                 div_done;
    logic [WIDTH-1:0]     div_q;
    logic [WIDTH-1:0]     div_r;

    logic                 stall;
    logic                 busy;
    logic                 hilo_we;
    logic [2*WIDTH-1:0]   hilo_wdata;
    logic                 exc_divzero;

    modport master (
        output op_valid, op_code, op_a, op_b, flush,
        output mul_result, div_done, div_q, div_r,
        input  mul_start, mul_signed, mul_a, mul_b, div_start, div_cancel,
        input  stall, busy, hilo_we, hilo_wdata, exc_divzero
    );

    modport slave (
        input  op_valid, op_code, op_a, op_b, flush,
        input  mul_result, div_done, div_q, div_r,
        output mul_start, mul_signed, mul_a, mul_b, div_start, div_cancel,
        output stall, busy, hilo_we, hilo_wdata, exc_divzero
    );
endinterface

// File: rtl/muldiv_sched.sv
// EX-stage multiply/divide scheduler.
// Starts one MULT/MULTU/DIV/DIVU op at a time on either the fixed-latency
// multiplier or the handshaked divider. It stalls the front of the pipe while
// the op is in flight and writes {HI,LO} with a single-cycle hilo_we.
// Optional feature: define MULDIV_DIVZERO_TRAP_EN to raise exc_divzero on a
// divide by zero. When it is undefined, a divide by zero retires silently.
module muldiv_sched #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 4
) (
    input  logic           clk,
    input  logic           rst,     // asynchronous, active-low
    muldiv_sched_if.slave  bus
);
    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_LAT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_WAIT = 2'd1,
        DIV_WAIT = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t               state, state_nx;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   hilo_q;
    logic                 signed_q;
    logic                 zero_div;

    logic issue, cap_mul, cap_div;
    logic stall, mul_start, div_start, div_cancel, hilo_we, exc_divzero;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next-state and control outputs. Flush outranks completion in every state.
    always_comb begin
        state_nx    = state;
        issue       = 1'b0;
        cap_mul     = 1'b0;
        cap_div     = 1'b0;
        stall       = 1'b0;
        mul_start   = 1'b0;
        div_start   = 1'b0;
        div_cancel  = 1'b0;
        hilo_we     = 1'b0;
        exc_divzero = 1'b0;
        case (state)
            IDLE: begin
                // Gating on rst keeps every output low while reset is held.
                if (rst && bus.op_valid && !bus.flush) begin
                    issue = 1'b1;
                    stall = 1'b1;
                    if (!bus.op_code[1]) begin
                        mul_start = 1'b1;
                        state_nx  = MUL_WAIT;
                    end else if (bus.op_b != '0) begin
                        div_start = 1'b1;
                        state_nx  = DIV_WAIT;
                    end else begin
                        // Divide by zero never reaches the divider.
                        state_nx  = DONE;
                    end
                end
            end
            MUL_WAIT: begin
                stall = 1'b1;
                if (bus.flush) begin
                    state_nx = IDLE;
                end else if (cnt == '0) begin
                    cap_mul  = 1'b1;
                    state_nx = DONE;
                end
            end
            DIV_WAIT: begin
                stall = 1'b1;
                if (bus.flush) begin
                    div_cancel = 1'b1;
                    state_nx   = IDLE;
                end else if (bus.div_done) begin
                    cap_div  = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                // op_valid here is the retiring instruction itself, so it is ignored.
                state_nx = IDLE;
                hilo_we  = !zero_div && !bus.flush;
`ifdef MULDIV_DIVZERO_TRAP_EN
                exc_divzero = zero_div && !bus.flush;
`else
                exc_divzero = 1'b0;
`endif
            end
            default: state_nx = IDLE;
        endcase
    end

    // Latency counter, signedness, zero-divide flag and the HI/LO result holding register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            hilo_q   <= '0;
            signed_q <= 1'b0;
            zero_div <= 1'b0;
        end else begin
            if (issue) begin
                signed_q <= ~bus.op_code[0];
                zero_div <= bus.op_code[1] && (bus.op_b == '0);
                if (!bus.op_code[1]) cnt <= CNT_INIT;
            end else if (state == MUL_WAIT && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (cap_mul)      hilo_q <= bus.mul_result;
            else if (cap_div) hilo_q <= {bus.div_r, bus.div_q};
        end
    end

    // Signedness is valid alongside the start pulse and held for the whole op.
    assign bus.mul_signed  = issue ? ~bus.op_code[0] : signed_q;
    assign bus.mul_a       = bus.op_a;
    assign bus.mul_b       = bus.op_b;
    assign bus.mul_start   = mul_start;
    assign bus.div_start   = div_start;
    assign bus.div_cancel  = div_cancel;
    assign bus.stall       = stall;
    assign bus.busy        = (state != IDLE);
    assign bus.hilo_we     = hilo_we;
    assign bus.hilo_wdata  = hilo_q;
    assign bus.exc_divzero = exc_divzero;
endmodule

// File: tb/tb_muldiv_sched.sv
// Bench for muldiv_sched: a vector table of directed cases, hand sequences for
// reset and back-to-back issue, and randomized ops. Each check compares the DUT
// against a cycle-level expectation built from op latency and flush position.
`timescale 1ns/1ps
module tb_muldiv_sched;
    localparam int WIDTH   = 32;
    localparam int MUL_LAT = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    muldiv_sched_if #(.WIDTH(WIDTH)) bus ();
    muldiv_sched #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    logic [63:0] hilo_m = '0;   // expected HI/LO contents

    // Reference arithmetic for the four ops.
    function automatic logic [63:0] ref_mul(input logic sg, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        longint unsigned ua, ub;
        if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        return ua * ub;
    endfunction

    function automatic logic [63:0] ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        if (b == 0) return '0;
        if (sg) begin
            sa = $signed(a);
            sb = $signed(b);
            return {32'(sa % sb), 32'(sa / sb)};
        end
        return {a % b, a / b};
    endfunction

    function automatic logic [63:0] ref_result(input logic [1:0] code, input logic [31:0] a, input logic [31:0] b);
        if (!code[1]) return ref_mul(~code[0], a, b);
        return ref_div(~code[0], a, b);
    endfunction

    // Behavioural multiplier and divider around the DUT. The divider ignores
    // cancel on purpose, so that a late div_done reaches the scheduler.
    int mul_cd = 0;
    logic [63:0] mul_p = '0;
    int div_cd = 0;
    int div_lat = 1;
    logic [63:0] div_p = '0;

    always @(posedge clk) begin
        if (bus.mul_start) begin
            mul_cd <= MUL_LAT;
            mul_p  <= ref_mul(bus.mul_signed, bus.mul_a, bus.mul_b);
        end else if (mul_cd > 0) begin
            mul_cd <= mul_cd - 1;
        end
        if (bus.div_start) begin
            div_cd <= div_lat;
            div_p  <= ref_div(bus.mul_signed, bus.mul_a, bus.mul_b);
        end else if (div_cd > 0) begin
            div_cd <= div_cd - 1;
        end
    end

    always_comb begin
        bus.mul_result = (mul_cd == 1) ? mul_p : 64'hBAD0_BAD1_BAD2_BAD3;
        bus.div_done   = (div_cd == 1);
        bus.div_q      = (div_cd == 1) ? div_p[31:0]  : 32'hDEAD_0001;
        bus.div_r      = (div_cd == 1) ? div_p[63:32] : 32'hDEAD_0002;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // {busy, stall, mul_start, div_start, div_cancel, hilo_we, exc_divzero}
    function automatic logic [6:0] obs();
        return {bus.busy, bus.stall, bus.mul_start, bus.div_start,
                bus.div_cancel, bus.hilo_we, bus.exc_divzero};
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle ctl", 64'(obs()), 64'd0);
            @(posedge clk); #1;
        end
    endtask

    // Present one op starting now (just after a rising edge).
    // f = cycle offset of a one-cycle flush, or -1 for none. With chain set,
    // the caller issues the next op in the cycle right after DONE.
    task automatic do_op(input string tag, input logic [1:0] code, input logic [31:0] a,
                         input logic [31:0] b, input int dlat, input int f, input bit chain,
                         input logic [63:0] res);
        bit is_mul, zd, killed;
        int n, last;
        logic [6:0] e;
        logic sg;
        is_mul = !code[1];
        zd     = code[1] && (b == 0);
        n      = is_mul ? MUL_LAT + 1 : (zd ? 1 : dlat + 1);
        killed = (f >= 0) && (f < n);
        last   = killed ? f + 1 : (chain ? n : n + 1);
        sg     = ~code[0];
        div_lat     = dlat;
        bus.op_code = code;
        bus.op_a    = a;
        bus.op_b    = b;
        for (int t = 0; t <= last; t++) begin
            bus.op_valid = (t <= n) && !(f >= 0 && t > f);
            bus.flush    = (t == f);
            e = '0;
            if (t == 0) begin
                if (f != 0) begin
                    e[5] = 1'b1;
                    e[4] = is_mul;
                    e[3] = !is_mul && !zd;
                end
            end else if (f >= 0 && t > f) begin
                e = '0;
            end else if (t < n) begin
                e[6] = 1'b1;
                e[5] = 1'b1;
                e[2] = (t == f) && !is_mul;
            end else if (t == n) begin
                e[6] = 1'b1;
                e[1] = !zd && (t != f);
`ifdef MULDIV_DIVZERO_TRAP_EN
                e[0] = zd && (t != f);
`endif
            end
            @(negedge clk);
            chk({tag, " ctl"}, 64'(obs()), 64'(e));
            if (t == 0 && f != 0) chk({tag, " signed"}, 64'(bus.mul_signed), 64'(sg));
            if (e[1]) chk({tag, " wdata"}, bus.hilo_wdata, res);
            @(posedge clk); #1;
        end
        bus.op_valid = 1'b0;
        bus.flush    = 1'b0;
        if (!zd && !killed && f != 0) hilo_m = res;
        chk({tag, " held"}, bus.hilo_wdata, hilo_m);
    endtask

    typedef struct {
        logic [1:0]  code;
        logic [31:0] a;
        logic [31:0] b;
        int          dlat;
        int          f;
        logic [63:0] res;
    } vec_t;

    vec_t tbl[11];

    logic [1:0]  rc;
    logic [31:0] ra, rb;
    int          rd, rf, rn;
    bit          rch;

    initial begin
        tbl[0]  = '{2'b00, 32'hFFFF_FFFD, 32'd7,         1,  -1, 64'hFFFF_FFFF_FFFF_FFEB};
        tbl[1]  = '{2'b11, 32'd100,       32'd7,         10, -1, {32'd2, 32'd14}};
        tbl[2]  = '{2'b10, 32'd5,         32'd0,         1,  -1, 64'd0};
        tbl[3]  = '{2'b10, 32'd100,       32'd7,         10,  3, 64'd0};
        tbl[4]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1,  -1, 64'hFFFF_FFFE_0000_0001};
        tbl[5]  = '{2'b10, 32'hFFFF_FFF9, 32'd2,         3,  -1, 64'hFFFF_FFFF_FFFF_FFFD};
        tbl[6]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 1,  -1, 64'h4000_0000_0000_0000};
        tbl[7]  = '{2'b11, 32'd9,         32'd4,         2,   3, {32'd1, 32'd2}};
        tbl[8]  = '{2'b00, 32'd12,        32'd12,        1,   2, 64'd144};
        tbl[9]  = '{2'b11, 32'd7,         32'd0,         1,  -1, 64'd0};
        tbl[10] = '{2'b00, 32'd12,        32'hFFFF_FFFF, 1,   0, 64'hFFFF_FFFF_FFFF_FFF4};

        bus.op_valid = 1'b0;
        bus.op_code  = 2'b00;
        bus.op_a     = '0;
        bus.op_b     = '0;
        bus.flush    = 1'b0;

        // Reset state
        #12;
        chk("reset ctl", 64'(obs()), 64'd0);
        chk("reset wdata", bus.hilo_wdata, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        idle(2);

        // Directed vector table
        foreach (tbl[i]) begin
            do_op($sformatf("vec%0d", i), tbl[i].code, tbl[i].a, tbl[i].b,
                  tbl[i].dlat, tbl[i].f, 1'b0, tbl[i].res);
            idle(12);
        end

        // Back-to-back MULTU: the second op issues in the cycle after DONE
        do_op("b2b0", 2'b01, 32'd3, 32'd5, 1, -1, 1'b1, 64'd15);
        do_op("b2b1", 2'b01, 32'd7, 32'd9, 1, -1, 1'b0, 64'd63);
        idle(2);

        // Asynchronous reset in the middle of MUL_WAIT
        bus.op_code  = 2'b00;
        bus.op_a     = 32'd5;
        bus.op_b     = 32'd6;
        bus.op_valid = 1'b1;
        @(negedge clk);
        chk("rstmid issue", 64'(obs()), 64'b0110000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstmid wait", 64'(obs()), 64'b1100000);
        #1 rst = 1'b0;
        #1;
        chk("rstmid ctl", 64'(obs()), 64'd0);
        chk("rstmid wdata", bus.hilo_wdata, 64'd0);
        hilo_m = '0;
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        rst = 1'b1;
        idle(8);

        // Randomized ops against the reference model
        for (int i = 0; i < 150; i++) begin
            rc = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 20));
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 20));
            if (rc[1] && $urandom_range(0, 5) == 0) rb = '0;
            if (rc == 2'b10 && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd1;
            rd = int'($urandom_range(1, 12));
            rn = !rc[1] ? MUL_LAT + 1 : ((rb == 0) ? 1 : rd + 1);
            if ($urandom_range(0, 3) == 0) rf = int'($urandom_range(0, rn));
            else                           rf = -1;
            rch = (rf < 0) && ($urandom_range(0, 1) == 1);
            do_op("rnd", rc, ra, rb, rd, rf, rch, ref_result(rc, ra, rb));
            if (!rch) idle((rf >= 0) ? 13 : int'($urandom_range(0, 2)));
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
